// File: rtl/enm_hit_tracker.sv
// Hit tracker for four enemies: bullet/hit-box overlap, per-enemy HP with
// post-hit immunity, a priority-resolved hit pulse, saturating score and an all-dead flag.
module enm_hit_tracker #(
    parameter int HP_INIT = 100,
    parameter int DMG     = 5,
    parameter int BOX     = 32,
    parameter int COOL    = 10
) (
    input  logic       clk_10ms,
    input  logic       switch,
    input  logic [9:0] bulletx,
    input  logic [9:0] bullety,
    input  logic       bullet_vld,
    input  logic [9:0] enmx1,
    input  logic [9:0] enmx2,
    input  logic [9:0] enmx3,
    input  logic [9:0] enmx4,
    input  logic [9:0] enmy1,
    input  logic [9:0] enmy2,
    input  logic [9:0] enmy3,
    input  logic [9:0] enmy4,
    output logic [6:0] enmhp1,
    output logic [6:0] enmhp2,
    output logic [6:0] enmhp3,
    output logic [6:0] enmhp4,
    output logic       bullet_hit,
    output logic [7:0] score,
    output logic       clear
);

    typedef enum logic [1:0] {
        ALIVE   = 2'd0,
        COOLING = 2'd1,
        DEAD    = 2'd2
    } state_t;

    localparam int              CW       = (COOL > 1) ? $clog2(COOL) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(COOL - 1);
    localparam logic [6:0]      DMG_V    = 7'(DMG);
    localparam logic [6:0]      HP_V     = 7'(HP_INIT);
    localparam logic [10:0]     BOX_V    = 11'(BOX);

    logic [9:0]    ex_s [4];
    logic [9:0]    ey_s [4];
    state_t        state_r   [4];
    state_t        state_nxt_s [4];
    logic [6:0]    hp_r      [4];
    logic [6:0]    hp_nxt_s  [4];
    logic [6:0]    hp_hit_s  [4];
    logic [CW-1:0] cnt_r     [4];
    logic [CW-1:0] cnt_nxt_s [4];
    logic [3:0]    ovl_s;
    logic [3:0]    acc_s;
    logic [3:0]    win_s;
    logic [3:0]    kill_s;
    logic [8:0]    score_sum_s;
    logic [7:0]    score_nxt_s;
    logic          all_dead_s;

    assign ex_s[0] = enmx1;
    assign ex_s[1] = enmx2;
    assign ex_s[2] = enmx3;
    assign ex_s[3] = enmx4;
    assign ey_s[0] = enmy1;
    assign ey_s[1] = enmy2;
    assign ey_s[2] = enmy3;
    assign ey_s[3] = enmy4;

    assign enmhp1 = hp_r[0];
    assign enmhp2 = hp_r[1];
    assign enmhp3 = hp_r[2];
    assign enmhp4 = hp_r[3];

    // Overlap and hit eligibility; an enemy whose immunity expires on this edge can already be hit.
    always_comb begin
        ovl_s = 4'b0000;
        acc_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ovl_s[i] = bullet_vld
                && ({1'b0, bulletx} >= {1'b0, ex_s[i]})
                && ({1'b0, bulletx} <  ({1'b0, ex_s[i]} + BOX_V))
                && ({1'b0, bullety} >= {1'b0, ey_s[i]})
                && ({1'b0, bullety} <  ({1'b0, ey_s[i]} + BOX_V));
            acc_s[i] = ovl_s[i] && ((state_r[i] == ALIVE)
                || ((state_r[i] == COOLING) && (cnt_r[i] == CNT_LAST)));
        end
    end

    // Lowest-index eligible enemy wins the bullet.
    assign win_s = acc_s & (~acc_s + 4'd1);

    // Per-enemy FSM next state, HP and immunity counter.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_nxt_s[i] = state_r[i];
            hp_nxt_s[i]    = hp_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            kill_s[i]      = 1'b0;
            if (hp_r[i] > DMG_V) begin
                hp_hit_s[i] = hp_r[i] - DMG_V;
            end else begin
                hp_hit_s[i] = 7'd0;
            end
            if (win_s[i]) begin
                hp_nxt_s[i]    = hp_hit_s[i];
                cnt_nxt_s[i]   = {CW{1'b0}};
                kill_s[i]      = (hp_hit_s[i] == 7'd0);
                state_nxt_s[i] = (hp_hit_s[i] == 7'd0) ? DEAD : COOLING;
            end else begin
                case (state_r[i])
                    ALIVE: begin
                        state_nxt_s[i] = ALIVE;
                    end
                    COOLING: begin
                        if (cnt_r[i] == CNT_LAST) begin
                            state_nxt_s[i] = ALIVE;
                            cnt_nxt_s[i]   = {CW{1'b0}};
                        end else begin
                            cnt_nxt_s[i]   = cnt_r[i] + CW'(1);
                        end
                    end
                    DEAD: begin
                        hp_nxt_s[i] = 7'd0;
                    end
                    default: begin
                        state_nxt_s[i] = DEAD;
                        hp_nxt_s[i]    = 7'd0;
                    end
                endcase
            end
        end
    end

    // Score update with kill bonus and saturation; all-dead detection on next state.
    always_comb begin
        score_sum_s = {1'b0, score} + ((|kill_s) ? 9'd11 : 9'd1);
        if (|win_s) begin
            score_nxt_s = (score_sum_s > 9'd255) ? 8'hFF : score_sum_s[7:0];
        end else begin
            score_nxt_s = score;
        end
        all_dead_s = (state_nxt_s[0] == DEAD) && (state_nxt_s[1] == DEAD)
                  && (state_nxt_s[2] == DEAD) && (state_nxt_s[3] == DEAD);
    end

    // State registers; reset overrides any hit on the same edge.
    always_ff @(posedge clk_10ms) begin
        if (switch) begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= ALIVE;
                hp_r[i]    <= HP_V;
                cnt_r[i]   <= {CW{1'b0}};
            end
            bullet_hit <= 1'b0;
            score      <= 8'd0;
            clear      <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= state_nxt_s[i];
                hp_r[i]    <= hp_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
            end
            bullet_hit <= |win_s;
            score      <= score_nxt_s;
            clear      <= all_dead_s;
        end
    end

endmodule

// File: tb/tb_enm_hit_tracker.sv
// Scoreboard bench for enm_hit_tracker: a timestamp-based reference model predicts every
// cycle's outputs, and directed constant checks cover the named scenarios.
module tb_enm_hit_tracker;

    logic       clk = 1'b0;
    logic       sw;
    logic [9:0] bx, by;
    logic       vld;
    logic [9:0] ex [4];
    logic [9:0] ey [4];
    logic [6:0] hp1, hp2, hp3, hp4;
    logic       hit;
    logic [7:0] score;
    logic       clr;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    typedef struct {
        int hp1, hp2, hp3, hp4, hit, score, clr;
    } exp_t;
    exp_t sb [$];

    int m_hp [4];
    int m_rdy [4];
    int m_score, m_hit, m_clr, m_cyc;

    always #5 clk = ~clk;

    enm_hit_tracker dut (
        .clk_10ms(clk), .switch(sw),
        .bulletx(bx), .bullety(by), .bullet_vld(vld),
        .enmx1(ex[0]), .enmx2(ex[1]), .enmx3(ex[2]), .enmx4(ex[3]),
        .enmy1(ey[0]), .enmy2(ey[1]), .enmy3(ey[2]), .enmy4(ey[3]),
        .enmhp1(hp1), .enmhp2(hp2), .enmhp3(hp3), .enmhp4(hp4),
        .bullet_hit(hit), .score(score), .clear(clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: an enemy is hittable once the current cycle reaches its ready time.
    task automatic model_edge();
        exp_t e;
        int in_box, nh;
        if (sw) begin
            for (int i = 0; i < 4; i++) begin
                m_hp[i] = 100;
                m_rdy[i] = 0;
            end
            m_score = 0; m_hit = 0; m_clr = 0;
        end else begin
            m_hit = 0;
            for (int i = 0; i < 4; i++) begin
                in_box = (int'(bx) >= int'(ex[i])) && (int'(bx) < int'(ex[i]) + 32)
                      && (int'(by) >= int'(ey[i])) && (int'(by) < int'(ey[i]) + 32);
                if (m_hit == 0 && vld && in_box != 0 && m_hp[i] > 0 && m_cyc >= m_rdy[i]) begin
                    nh = (m_hp[i] > 5) ? m_hp[i] - 5 : 0;
                    m_hp[i] = nh;
                    m_rdy[i] = m_cyc + 10;
                    m_hit = 1;
                    m_score = m_score + ((nh == 0) ? 11 : 1);
                    if (m_score > 255) m_score = 255;
                end
            end
            m_clr = (m_hp[0] == 0 && m_hp[1] == 0 && m_hp[2] == 0 && m_hp[3] == 0) ? 1 : 0;
        end
        m_cyc++;
        e.hp1 = m_hp[0]; e.hp2 = m_hp[1]; e.hp3 = m_hp[2]; e.hp4 = m_hp[3];
        e.hit = m_hit; e.score = m_score; e.clr = m_clr;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_hp1", 32'(hp1), 32'(e.hp1));
            chk("sb_hp2", 32'(hp2), 32'(e.hp2));
            chk("sb_hp3", 32'(hp3), 32'(e.hp3));
            chk("sb_hp4", 32'(hp4), 32'(e.hp4));
            chk("sb_hit", 32'(hit), 32'(e.hit));
            chk("sb_score", 32'(score), 32'(e.score));
            chk("sb_clear", 32'(clr), 32'(e.clr));
        end
        if (hit === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        sw = 1'b1;
        vld = 1'b0;
        tick();
        sw = 1'b0;
    endtask

    task automatic hold(input int x, input int y, input int n);
        bx = 10'(x); by = 10'(y); vld = 1'b1;
        for (int k = 0; k < n; k++) tick();
        vld = 1'b0;
    endtask

    initial begin
        sw = 1'b1; vld = 1'b0; bx = 10'd0; by = 10'd0;
        m_cyc = 0; m_score = 0; m_hit = 0; m_clr = 0;
        for (int i = 0; i < 4; i++) begin m_hp[i] = 100; m_rdy[i] = 0; end
        ex[0] = 10'd248; ey[0] = 10'd40;
        ex[1] = 10'd312; ey[1] = 10'd150;
        ex[2] = 10'd312; ey[2] = 10'd150;
        ex[3] = 10'd600; ey[3] = 10'd300;

        // Reset state
        do_reset();
        do_reset();
        chk("rst_hp1", 32'(hp1), 32'd100);
        chk("rst_hp4", 32'(hp4), 32'd100);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_clear", 32'(clr), 32'd0);

        // Single hit on enemy 1
        hold(250, 50, 1);
        chk("hit1_hp1", 32'(hp1), 32'd95);
        chk("hit1_pulse", 32'(hit), 32'd1);
        chk("hit1_score", 32'(score), 32'd1);
        tick();
        chk("hit1_pulse_end", 32'(hit), 32'd0);

        // bullet_vld low suppresses everything
        bx = 10'd250; by = 10'd50; vld = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("novld_hp1", 32'(hp1), 32'd95);

        // Held bullet: immunity spaces hits 10 cycles apart
        do_reset();
        pulses = 0;
        hold(250, 50, 25);
        chk("hold_pulses", 32'(pulses), 32'd3);
        chk("hold_hp1", 32'(hp1), 32'd85);
        chk("hold_score", 32'(score), 32'd3);

        // Two overlapping enemies: lower index wins
        do_reset();
        pulses = 0;
        hold(320, 160, 1);
        chk("prio_hp2", 32'(hp2), 32'd95);
        chk("prio_hp3", 32'(hp3), 32'd100);
        tick();
        chk("prio_pulses", 32'(pulses), 32'd1);

        // Enemy 4 down to 5 HP, then killed, then ignored
        do_reset();
        pulses = 0;
        hold(610, 310, 181);
        chk("e4_hp5", 32'(hp4), 32'd5);
        hold(610, 310, 10);
        chk("e4_dead_hp", 32'(hp4), 32'd0);
        chk("e4_kill_score", 32'(score), 32'd30);
        pulses = 0;
        hold(610, 310, 30);
        chk("e4_dead_nopulse", 32'(pulses), 32'd0);
        chk("e4_dead_hold", 32'(hp4), 32'd0);

        // Kill the remaining three, clear rises, then reset restores everything
        hold(250, 50, 191);
        chk("e1_dead", 32'(hp1), 32'd0);
        chk("clear_partial", 32'(clr), 32'd0);
        hold(320, 160, 200);
        chk("all_clear", 32'(clr), 32'd1);
        chk("all_score", 32'(score), 32'd120);
        bx = 10'd250; by = 10'd50; vld = 1'b1;
        do_reset();
        chk("rrst_hp1", 32'(hp1), 32'd100);
        chk("rrst_hp3", 32'(hp3), 32'd100);
        chk("rrst_score", 32'(score), 32'd0);
        chk("rrst_clear", 32'(clr), 32'd0);

        // Hit-box edges and no wrap at the right screen edge
        hold(280, 50, 1);
        chk("edge32_miss", 32'(hit), 32'd0);
        hold(279, 71, 1);
        chk("edge31_hit", 32'(hp1), 32'd95);
        ex[0] = 10'd1000;
        do_reset();
        hold(1023, 50, 1);
        chk("nowrap_hit", 32'(hp1), 32'd95);
        chk("nowrap_pulse", 32'(hit), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
